// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle byte-enabled data memory with stall/resp_valid handshake.
// Define DMEM_RESP_ERR_EN to flag and suppress accesses beyond 2^ADDR_W words.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] resp_rdata,
  output logic        resp_valid,
  output logic        stall,
  output logic        resp_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] wen_q, a_wen;
  logic [31:0] addr_q, wdata_q, a_addr, a_wdata, rdata_q, rdata_d, stored, bmask, merged;
  logic err_q, err_d, oor, cap, enter, unused_bits;
  logic [31:0] mem [2**ADDR_W];
  assign cap = (state_q == IDLE) && req_en;
  // With LATENCY=1 the access happens on the capture edge, so use the live request.
  assign a_wen   = (state_q == IDLE) ? req_wen   : wen_q;
  assign a_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign a_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign stored  = mem[a_addr[ADDR_W+1:2]];
  assign bmask   = {{8{a_wen[3]}}, {8{a_wen[2]}}, {8{a_wen[1]}}, {8{a_wen[0]}}};
  assign merged  = (a_wdata & bmask) | (stored & ~bmask);
  assign unused_bits = ^{a_addr[1:0], a_addr[31:ADDR_W+2]};
`ifdef DMEM_RESP_ERR_EN
  assign oor = |a_addr[31:ADDR_W+2];
`else
  assign oor = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_en) begin
        state_d = (LATENCY > 1) ? BUSY : RESP;
        cnt_d   = 3'(LATENCY - 1);
      end
      BUSY: begin
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q == 3'd1) ? RESP : BUSY;
      end
      default: state_d = IDLE;
    endcase
  end
  assign enter   = (state_d == RESP) && (state_q != RESP);
  assign rdata_d = enter ? (oor ? 32'h0 : merged) : rdata_q;
  assign err_d   = enter ? oor : err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      wen_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (cap) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end
  // Storage is never reset; a reset held across the commit edge blocks the write.
  always_ff @(posedge clk) begin
    if (rst && enter && !oor) mem[a_addr[ADDR_W+1:2]] <= merged;
  end
  assign resp_valid = (state_q == RESP);
  assign stall      = cap || (state_q == BUSY);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q && resp_valid;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench; DUT a has LATENCY=2, DUT b has LATENCY=1.
module tb_dmem_responder;
  localparam int LA = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic a_req_en = 1'b0, b_req_en = 1'b0;
  logic [3:0] a_req_wen = '0, b_req_wen = '0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0, b_req_addr = '0, b_req_wdata = '0;
  logic [31:0] a_resp_rdata, b_resp_rdata;
  logic a_resp_valid, a_stall, a_resp_err, b_resp_valid, b_stall, b_resp_err;
  int checks = 0, failures = 0;
  logic [31:0] ma [1024], va [1024], mb [1024], vb [1024];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(LA)) dut_a (
    .clk(clk), .rst(rst), .req_en(a_req_en), .req_wen(a_req_wen), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .resp_rdata(a_resp_rdata), .resp_valid(a_resp_valid),
    .stall(a_stall), .resp_err(a_resp_err));
  dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .req_en(b_req_en), .req_wen(b_req_wen), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_rdata(b_resp_rdata), .resp_valid(b_resp_valid),
    .stall(b_stall), .resp_err(b_resp_err));

  // Reference: a word array plus a mask of bits that have ever been written.
  function automatic void model(input bit b, input logic [3:0] wen, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] exp,
                                output logic [31:0] mask, output logic err);
    int i;
    logic [31:0] bm;
    i = int'(addr[11:2]);
    bm = '0;
    for (int k = 0; k < 4; k++) if (wen[k]) bm = bm | (32'hFF << (8 * k));
    err = 1'b0;
`ifdef DMEM_RESP_ERR_EN
    if (addr[31:12] != 0) begin
      err = 1'b1;
      exp = 32'h0;
      mask = '1;
      return;
    end
`endif
    if (b) begin
      mb[i] = (mb[i] & ~bm) | (wdata & bm);
      vb[i] = vb[i] | bm;
      exp = mb[i];
      mask = vb[i];
    end else begin
      ma[i] = (ma[i] & ~bm) | (wdata & bm);
      va[i] = va[i] | bm;
      exp = ma[i];
      mask = va[i];
    end
  endfunction

  task automatic do_a(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit hold, input string nm);
    logic [31:0] exp, mask, held;
    logic err;
    model(1'b0, wen, addr, wdata, exp, mask, err);
    @(posedge clk); #1;
    a_req_en = 1'b1; a_req_wen = wen; a_req_addr = addr; a_req_wdata = wdata;
    #1;
    checks++;
    if (a_stall !== 1'b1 || a_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s c0: stall=%b valid=%b required stall=1 valid=0", nm, a_stall, a_resp_valid);
    end
    for (int c = 1; c < LA; c++) begin
      @(posedge clk); #1;
      if (!hold) begin
        a_req_en = 1'b0; a_req_addr = $urandom; a_req_wdata = $urandom; a_req_wen = 4'($urandom);
      end
      #1;
      checks++;
      if (a_stall !== 1'b1 || a_resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s busy c%0d: stall=%b valid=%b required stall=1 valid=0", nm, c, a_stall, a_resp_valid);
      end
    end
    @(posedge clk); #1;
    a_req_en = 1'b0; a_req_addr = $urandom; a_req_wdata = $urandom;
    #1;
    checks++;
    if (a_resp_valid !== 1'b1 || a_stall !== 1'b0 || ((a_resp_rdata ^ exp) & mask) !== 32'h0 ||
        a_resp_err !== err) begin
      failures++;
      $display("FAIL %s resp: valid=%b stall=%b rdata=%h err=%b required valid=1 stall=0 rdata=%h (mask %h) err=%b",
               nm, a_resp_valid, a_stall, a_resp_rdata, a_resp_err, exp, mask, err);
    end
    held = a_resp_rdata;
    @(posedge clk); #2;
    checks++;
    if (a_resp_valid !== 1'b0 || a_stall !== 1'b0 || a_resp_rdata !== held) begin
      failures++;
      $display("FAIL %s after: valid=%b stall=%b rdata=%h required valid=0 stall=0 rdata=%h",
               nm, a_resp_valid, a_stall, a_resp_rdata, held);
    end
  endtask

  // LATENCY=1: request cycle then response cycle, no idle gap afterwards.
  task automatic do_b(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input string nm);
    logic [31:0] exp, mask;
    logic err;
    model(1'b1, wen, addr, wdata, exp, mask, err);
    @(posedge clk); #1;
    b_req_en = 1'b1; b_req_wen = wen; b_req_addr = addr; b_req_wdata = wdata;
    #1;
    checks++;
    if (b_stall !== 1'b1 || b_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s c0: stall=%b valid=%b required stall=1 valid=0", nm, b_stall, b_resp_valid);
    end
    @(posedge clk); #1;
    b_req_en = 1'b0;
    #1;
    checks++;
    if (b_resp_valid !== 1'b1 || b_stall !== 1'b0 || ((b_resp_rdata ^ exp) & mask) !== 32'h0) begin
      failures++;
      $display("FAIL %s c1: valid=%b stall=%b rdata=%h required valid=1 stall=0 rdata=%h",
               nm, b_resp_valid, b_stall, b_resp_rdata, exp);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (a_resp_valid !== 1'b0 || a_stall !== 1'b0 || a_resp_rdata !== 32'h0 || a_resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: valid=%b stall=%b rdata=%h err=%b required all 0",
               a_resp_valid, a_stall, a_resp_rdata, a_resp_err);
    end
    a_req_en = 1'b1;
    #1;
    checks++;
    if (a_stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_stall: stall=%b required 1", a_stall);
    end
    a_req_en = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_store_load();
    do_a(4'hF, 32'h10, 32'hDEADBEEF, 1'b0, "store10");
    do_a(4'h0, 32'h10, 32'h0, 1'b0, "load10");
  endtask

  task automatic test_byte_merge();
    do_a(4'hF, 32'h20, 32'h11223344, 1'b0, "init20");
    do_a(4'b0010, 32'h20, 32'h0000AA00, 1'b0, "merge20");
    do_a(4'h0, 32'h22, 32'h0, 1'b0, "load20");
  endtask

  task automatic test_latency1();
    do_b(4'hF, 32'h0, 32'hA5A50001, "b_init0");
    do_b(4'hF, 32'h4, 32'h5A5A0004, "b_init4");
    do_b(4'h0, 32'h0, 32'h0, "b_load0");
    do_b(4'h0, 32'h4, 32'h0, "b_load4");
    @(posedge clk); #2;
    checks++;
    if (b_stall !== 1'b0 || b_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b_idle: stall=%b valid=%b required 0 0", b_stall, b_resp_valid);
    end
  endtask

  task automatic test_reset_busy();
    do_a(4'hF, 32'h30, 32'h0, 1'b0, "zero30");
    do_a(4'hF, 32'h34, 32'hCAFEF00D, 1'b0, "store34");
    @(posedge clk); #1;
    a_req_en = 1'b1; a_req_wen = 4'hF; a_req_addr = 32'h30; a_req_wdata = 32'h12345678;
    @(posedge clk); #1;
    a_req_en = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (a_stall !== 1'b0 || a_resp_valid !== 1'b0 || a_resp_rdata !== 32'h0 || a_resp_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy: stall=%b valid=%b rdata=%h err=%b required all 0",
               a_stall, a_resp_valid, a_resp_rdata, a_resp_err);
    end
    #1 rst = 1'b1;
    do_a(4'h0, 32'h30, 32'h0, 1'b0, "load30_a");
    @(posedge clk); #1;
    a_req_en = 1'b1; a_req_wen = 4'hF; a_req_addr = 32'h30; a_req_wdata = 32'h87654321;
    @(posedge clk); #1;
    a_req_en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_a(4'h0, 32'h30, 32'h0, 1'b0, "load30_b");
  endtask

  task automatic test_range();
    do_a(4'hF, 32'h0, 32'h01020304, 1'b0, "init0");
    do_a(4'hF, 32'h00001000, 32'h5A5A5A5A, 1'b0, "store1000");
    do_a(4'h0, 32'h0, 32'h0, 1'b0, "load0");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp, mask, wd;
    logic err;
    int pulses = 0;
    wd = $urandom;
    model(1'b0, 4'h1, 32'h40, wd, exp, mask, err);
    @(posedge clk); #1;
    a_req_en = 1'b1; a_req_wen = 4'h1; a_req_addr = 32'h40; a_req_wdata = wd;
    for (int k = 0; k < 3 * (LA + 1); k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      #1;
      if (a_resp_valid === 1'b1) pulses++;
      checks++;
      if (a_stall !== ((k % (LA + 1)) < LA) || a_resp_valid !== ((k % (LA + 1)) == LA) ||
          (a_resp_valid && ((a_resp_rdata ^ exp) & mask) !== 32'h0)) begin
        failures++;
        $display("FAIL hold c%0d: stall=%b valid=%b rdata=%h required stall=%b valid=%b rdata=%h",
                 k, a_stall, a_resp_valid, a_resp_rdata, (k % (LA + 1)) < LA, (k % (LA + 1)) == LA, exp);
      end
    end
    a_req_en = 1'b0;
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL hold_count: pulses=%0d required 3", pulses);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      addr = {18'h0, 4'($urandom), 2'($urandom)} + 32'h100;
      if ($urandom_range(0, 6) == 0) addr = addr | (32'($urandom_range(1, 3)) << 12);
      do_a(4'($urandom), addr, $urandom, 1'($urandom), "rand");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ma[i] = '0; va[i] = '0; mb[i] = '0; vb[i] = '0;
    end
    test_reset();
    test_store_load();
    test_byte_merge();
    test_latency1();
    test_reset_busy();
    test_range();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
